// File: rtl/aes_pkg.sv
// AES-128 inverse-cipher primitives: S-box tables, round constants, GF(2^8) math, inverse round transforms.
// Latency: purely combinational helpers, no state.
// Backpressure: not applicable; callers own all flow control.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_NOKEY  = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_IDLE   = 3'd2,
    ST_DEC    = 3'd3,
    ST_OUT    = 3'd4
  } fsm_e;

  // Key-step direction select
  localparam logic KS_FWD = 1'b0;
  localparam logic KS_INV = 1'b1;

  // Table entry for byte b sits at index ~b (255-b): the first listed byte is the MSB.
  localparam logic [255:0][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0][7:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[~b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[~b];
  endfunction

  // Round constant for round i (1..10); zero outside that range.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h00;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    end
    return r;
  endfunction

  // Byte (row r, column c) lives at byte index 4c+r; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[127 - 8*(4*c + rw) -: 8] = s[127 - 8*(4*((c + 4 - rw) % 4) + rw) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      r[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      r[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      r[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward (rk_i -> rk_i+1) or inverse (rk_i -> rk_i-1) chosen by dir_i.
// Latency: combinational, zero cycles.
// Backpressure: none; the owning FSM decides when the result is captured.
module aes_key_step
  import aes_pkg::*;
(
  input  logic         dir_i,
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t3, sub_in, rot, g;
  logic [31:0] n0, n1, n2, n3;

  // Both directions feed the same four S-boxes; only the SubWord operand differs.
  always_comb begin
    w0 = key_i[127:96];
    w1 = key_i[95:64];
    w2 = key_i[63:32];
    w3 = key_i[31:0];
    t3 = w3 ^ w2;
    sub_in = (dir_i == KS_INV) ? t3 : w3;
    rot = {sub_in[23:0], sub_in[31:24]};
    g = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon_i, 24'h000000};
    n0 = w0 ^ g;
    if (dir_i == KS_INV) begin
      n1 = w1 ^ w0;
      n2 = w2 ^ w1;
      n3 = t3;
    end else begin
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
    end
    key_o = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor, one inverse round per clock, round keys regenerated backwards from rk10.
// Latency: key load -> key_ready in 10 clocks; ciphertext accept -> out_valid in 10 clocks.
// Backpressure: result held while out_ready is low; in_ready is low outside IDLE, so one block in flight.
module aes128_decrypt_iter
  import aes_pkg::*;
#(
  parameter int NR = 10  // AES-128 only; other round counts are not supported
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt_out,
  output logic         busy
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  fsm_e         fsm_q, fsm_d;
  logic [127:0] kreg_q, kreg_d;
  logic [127:0] rk10_q, rk10_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] pt_q, pt_d;
  logic [3:0]   rcnt_q, rcnt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         out_valid_q, out_valid_d;
  logic         key_ready_q, key_ready_d;

  logic         ks_dir;
  logic [127:0] ks_key;
  logic [7:0]   ks_rcon;
  logic [127:0] ks_out;
  logic [127:0] round_core;

  aes_key_step u_key_step (
    .dir_i  (ks_dir),
    .key_i  (ks_key),
    .rcon_i (ks_rcon),
    .key_o  (ks_out)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= ST_NOKEY;
    else     fsm_q <= fsm_d;
  end

  // FSM next state; key_load wins over in_valid in IDLE and is ignored elsewhere once a key exists
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_NOKEY:  if (key_load) fsm_d = ST_KEYEXP;
      ST_KEYEXP: if (rcnt_q == LAST_RND) fsm_d = ST_IDLE;
      ST_IDLE: begin
        if (key_load)      fsm_d = ST_KEYEXP;
        else if (in_valid) fsm_d = ST_DEC;
      end
      ST_DEC:    if (rnd_q == 4'd0) fsm_d = ST_OUT;
      ST_OUT:    if (out_ready) fsm_d = ST_IDLE;
      default:   fsm_d = ST_NOKEY;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (fsm_q == ST_IDLE) && !key_load;
    busy      = (fsm_q == ST_KEYEXP) || (fsm_q == ST_DEC);
    out_valid = out_valid_q;
    key_ready = key_ready_q;
    pt_out    = pt_q;
  end

  // Steer the shared key step: forward during expansion, inverse from rk10 on accept and from kreg per round
  always_comb begin
    ks_dir  = KS_INV;
    ks_key  = kreg_q;
    ks_rcon = 8'h00;
    case (fsm_q)
      ST_KEYEXP: begin
        ks_dir  = KS_FWD;
        ks_rcon = rcon(rcnt_q);
      end
      ST_IDLE: begin
        ks_key  = rk10_q;
        ks_rcon = rcon(LAST_RND);
      end
      ST_DEC:  ks_rcon = rcon(rnd_q);
      default: ks_rcon = 8'h00;
    endcase
  end

  // Datapath next state: key schedule, round transform and output capture
  always_comb begin
    kreg_d      = kreg_q;
    rk10_d      = rk10_q;
    blk_d       = blk_q;
    pt_d        = pt_q;
    rcnt_d      = rcnt_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
    key_ready_d = key_ready_q;
    round_core  = inv_sub_bytes(inv_shift_rows(blk_q)) ^ kreg_q;
    case (fsm_q)
      ST_NOKEY: begin
        if (key_load) begin
          kreg_d = key_in;
          rcnt_d = 4'd1;
        end
      end
      ST_KEYEXP: begin
        kreg_d = ks_out;
        rcnt_d = rcnt_q + 4'd1;
        if (rcnt_q == LAST_RND) begin
          rk10_d      = ks_out;
          key_ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (key_load) begin
          kreg_d      = key_in;
          rcnt_d      = 4'd1;
          key_ready_d = 1'b0;
        end else if (in_valid) begin
          blk_d  = ct_in ^ rk10_q;
          kreg_d = ks_out;
          rnd_d  = LAST_RND - 4'd1;
        end
      end
      ST_DEC: begin
        if (rnd_q != 4'd0) begin
          blk_d  = inv_mix_columns(round_core);
          kreg_d = ks_out;
          rnd_d  = rnd_q - 4'd1;
        end else begin
          // Final round has no InvMixColumns; kreg holds rk0 here
          pt_d        = round_core;
          out_valid_d = 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset discards any block in flight and the stored key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kreg_q      <= '0;
      rk10_q      <= '0;
      blk_q       <= '0;
      pt_q        <= '0;
      rcnt_q      <= '0;
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
      key_ready_q <= 1'b0;
    end else begin
      kreg_q      <= kreg_d;
      rk10_q      <= rk10_d;
      blk_q       <= blk_d;
      pt_q        <= pt_d;
      rcnt_q      <= rcnt_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
      key_ready_q <= key_ready_d;
    end
  end

endmodule

// File: doc/aes128_decrypt_iter.md
Name: aes128_decrypt_iter

Overview:
- Standalone iterative AES-128 decryption core (FIPS-197 inverse cipher) with valid/ready handshakes on both sides.
- Executes one decryption round per clock and derives round keys in reverse on the fly, starting from a stored last round key.
- Sits downstream of the encrypt datapath as the receive-side counterpart, so no 11×128-bit key array is needed.

Parameters:
- NR, 10, number of rounds (fixed for AES-128; any other value is unsupported).

Ports:
- clk  in  1  clock, all flops on rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_load  in  1  pulse: capture key_in and start key expansion.
- key_in  in  128  cipher key; bits [127:120] are byte 0.
- key_ready  out  1  high once round key 10 is stored and valid.
- in_valid  in  1  ciphertext valid.
- in_ready  out  1  core accepts ciphertext.
- ct_in  in  128  ciphertext; bits [127:120] are byte 0, column-major.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  sink accepts plaintext.
- pt_out  out  128  plaintext.
- busy  out  1  high in KEYEXP or DEC.

Behaviour:
- Reset (async, rst=1): FSM goes to NOKEY. key_ready, in_ready, out_valid and busy are 0; pt_out, state register, key register and rk10 register are all 0.
- NOKEY: in_ready=0.
  - key_load=1 → KEYEXP; kreg<=key_in; rcnt<=1.
- KEYEXP: forward key expansion, one round per cycle: kreg<=fwd_step(kreg, rcon[rcnt]).
  - After 10 cycles, rk10<=result, key_ready<=1 → IDLE.
  - key_load and in_valid are ignored in this state; key_ready=0 throughout.
- IDLE: in_ready = !key_load.
  - key_load=1 has priority: same actions as in NOKEY, key_ready<=0.
  - in_valid & in_ready: state<=ct_in ^ rk10; kreg<=inv_step(rk10, rcon[10]); rnd<=9 → DEC.
- DEC, rnd 9..1: state<=InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), kreg)); kreg<=inv_step(kreg, rcon[rnd]); rnd<=rnd-1.
- DEC, rnd=0 (kreg holds rk0): pt_out<=InvSubBytes(InvShiftRows(state)) ^ kreg; out_valid<=1 → OUT.
- Latency: out_valid rises exactly 10 clocks after the ct_in accept edge.
- OUT: pt_out and out_valid stay stable until out_ready=1. On the out_ready edge, out_valid<=0 → IDLE.
  - Out_ready may already be high when out_valid rises; the transfer then completes on the next edge.
- Throughput: one block per 12 cycles at best, because in_ready is deasserted in DEC and OUT.
- key_load is ignored in KEYEXP, DEC and OUT. A new key never corrupts an in-flight block.
- inv_step(rk_i → rk_{i-1}), words w0..w3 with w0 at [127:96]:
  - w3'=w3^w2; w2'=w2^w1; w1'=w1^w0.
  - w0'=w0^SubWord(RotWord(w3'))^{rcon_i,00,00,00}.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- GF(2^8) arithmetic uses polynomial 0x11b. InvMixColumns coefficients are 0e,0b,0d,09.
- Reset asserted mid-KEYEXP, mid-DEC or in OUT: the core immediately returns to NOKEY. The block is lost and a key must be reloaded.

Decomposition:
- Package aes_pkg:
  - SBOX and INV_SBOX function tables.
  - rcon function.
  - xtime and gmul functions.
  - InvShiftRows and InvMixColumns functions.
  - FSM state enum (NOKEY, KEYEXP, IDLE, DEC, OUT).
- Sub-module aes_key_step: combinational fwd/inv key step selected by a dir input, shared by KEYEXP and DEC so only one set of 4 S-boxes is instantiated.

Test Plan:
- Load key 000102030405060708090a0b0c0d0e0f → key_ready after 10 KEYEXP cycles; internal rk10 = 13111d7fe3944a17f307a78b4d2b30c5.
- With that key, send ct 69c4e0d86a7b0430d8cdb78070b4c55a → pt_out = 00112233445566778899aabbccddeeff, out_valid exactly 10 clocks after accept.
- Load key 2b7e151628aed2a6abf7158809cf4f3c (rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6), send ct 3925841d02dc09fbdc118597196a0b32 → pt 3243f6a8885a308d313198a2e0370734.
- Backpressure check:
  - Hold out_ready=0 for 20 cycles → pt_out and out_valid stable, in_ready=0.
  - Release out_ready → one transfer, then in_ready=1.
- Pulse key_load during DEC → ignored and the current result is still correct. Assert key_load and in_valid together in IDLE → key wins, no block is accepted, key_ready drops.
- Assert rst at DEC round 5 → all outputs 0 asynchronously. in_ready stays 0 until a new key_load completes KEYEXP.
